// File: rtl/wino_pkg.sv
// rtl/wino_pkg.sv - shared Winograd tile constants, fetch state encoding and helpers
package wino_pkg;

  localparam int ID_W_DEF    = 4;
  localparam int BLK_W_DEF   = 8;
  localparam int COORD_W_DEF = 11;

  localparam int STRIDE_F43    = 4;
  localparam int STRIDE_F63    = 6;
  localparam int TILE_ROWS_F43 = 6;
  localparam int TILE_ROWS_F63 = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  // size_type 1 selects F(4,3), 0 selects F(6,3)
  function automatic logic [2:0] stride_of(input logic size_type);
    return size_type ? 3'(STRIDE_F43) : 3'(STRIDE_F63);
  endfunction

  // index of the last row inside one input tile
  function automatic logic [2:0] row_last_of(input logic size_type);
    return size_type ? 3'(TILE_ROWS_F43 - 1) : 3'(TILE_ROWS_F63 - 1);
  endfunction

endpackage

// File: rtl/tile_coord_counter.sv
// rtl/tile_coord_counter.sv - nested row/bx/by walk with incremental pixel coordinates
module tile_coord_counter
  import wino_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int BLK_W   = BLK_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               advance,
  input  logic [2:0]         stride,
  input  logic [2:0]         row_last,
  input  logic [BLK_W-1:0]   width_last,
  input  logic [BLK_W-1:0]   height_last,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               tile_last,
  output logic               slice_last
);

  logic [2:0]         r;
  logic [BLK_W-1:0]   bx;
  logic [BLK_W-1:0]   by;
  logic [COORD_W-1:0] row_base;
  logic [COORD_W-1:0] stride_ext;

  assign stride_ext = COORD_W'(stride);
  assign tile_last  = (r == row_last);
  assign slice_last = tile_last && (bx == width_last) && (by == height_last);

  // row innermost, then bx, then by; row_base tracks by*stride so row = row_base + r
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r        <= '0;
      bx       <= '0;
      by       <= '0;
      row      <= '0;
      col      <= '0;
      row_base <= '0;
    end else if (advance) begin
      if (!tile_last) begin
        r   <= r + 3'd1;
        row <= row + COORD_W'(1);
      end else begin
        r <= '0;
        if (bx != width_last) begin
          bx  <= bx + BLK_W'(1);
          col <= col + stride_ext;
          row <= row_base;
        end else begin
          bx       <= '0;
          by       <= by + BLK_W'(1);
          col      <= '0;
          row_base <= row_base + stride_ext;
          row      <= row_base + stride_ext;
        end
      end
    end
  end

endmodule

// File: rtl/data_tile_fetcher.sv
// rtl/data_tile_fetcher.sv - per-slice tile row-read sequencer; DATA_TILE_FETCHER_PERF_EN adds stall_cnt_o
module data_tile_fetcher
  import wino_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int ID_W    = ID_W_DEF,
  parameter int BLK_W   = BLK_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               size_type_i,
  input  logic               data_prepare_i,
  input  logic [BLK_W-1:0]   block_width_i,
  input  logic [BLK_W-1:0]   block_height_i,
  input  logic [ID_W-1:0]    data_id_i,
  output logic               rd_valid_o,
  input  logic               rd_ready_i,
  output logic [ID_W-1:0]    rd_id_o,
  output logic [COORD_W-1:0] rd_row_o,
  output logic [COORD_W-1:0] rd_col_o,
  output logic               rd_tile_last_o,
  output logic               loop_finished_o,
`ifdef DATA_TILE_FETCHER_PERF_EN
  output logic [15:0]        stall_cnt_o,
`endif
  output logic               busy_o
);

  fetch_state_e     state;
  logic             size_type_q;
  logic [BLK_W-1:0] width_last_q;
  logic [BLK_W-1:0] height_last_q;
  logic             start;
  logic             accept;
  logic             tile_last;
  logic             slice_last;

  assign start          = (state == ST_IDLE) && data_prepare_i;
  assign accept         = rd_valid_o && rd_ready_i;
  assign rd_tile_last_o = rd_valid_o && tile_last;

  tile_coord_counter #(
    .COORD_W(COORD_W),
    .BLK_W  (BLK_W)
  ) u_coord (
    .clk        (clk),
    .reset      (reset),
    .clear      (start),
    .advance    (accept),
    .stride     (stride_of(size_type_q)),
    .row_last   (row_last_of(size_type_q)),
    .width_last (width_last_q),
    .height_last(height_last_q),
    .row        (rd_row_o),
    .col        (rd_col_o),
    .tile_last  (tile_last),
    .slice_last (slice_last)
  );

  // handshake FSM: outputs are registered alongside the state so nothing depends on rd_ready_i combinationally
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      size_type_q     <= 1'b0;
      width_last_q    <= '0;
      height_last_q   <= '0;
      rd_id_o         <= '0;
      rd_valid_o      <= 1'b0;
      loop_finished_o <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (data_prepare_i) begin
            size_type_q   <= size_type_i;
            width_last_q  <= block_width_i - BLK_W'(1);
            height_last_q <= block_height_i - BLK_W'(1);
            rd_id_o       <= data_id_i;
            busy_o        <= 1'b1;
            if ((block_width_i == '0) || (block_height_i == '0)) begin
              state           <= ST_DONE;
              loop_finished_o <= 1'b1;
            end else begin
              state      <= ST_FETCH;
              rd_valid_o <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (accept && slice_last) begin
            state           <= ST_DONE;
            rd_valid_o      <= 1'b0;
            loop_finished_o <= 1'b1;
          end
        end
        ST_DONE: begin
          state           <= ST_DRAIN;
          loop_finished_o <= 1'b0;
        end
        ST_DRAIN: begin
          if (!data_prepare_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state           <= ST_IDLE;
          rd_valid_o      <= 1'b0;
          loop_finished_o <= 1'b0;
          busy_o          <= 1'b0;
        end
      endcase
    end
  end

`ifdef DATA_TILE_FETCHER_PERF_EN
  // saturating count of cycles a request waited on the line buffer; restarts with each slice
  always_ff @(posedge clk) begin
    if (reset || start) begin
      stall_cnt_o <= '0;
    end else if (rd_valid_o && !rd_ready_i && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule
